// File: rtl/cmd_ximm_pkg.sv
// rtl/cmd_ximm_pkg.sv - shared widths, depths and payload types for the cmd/ximm1 enqueue unit
package cmd_ximm_pkg;

  localparam int DEFAULT_CMD_W        = 32;
  localparam int DEFAULT_XIMM_W       = 64;
  localparam int DEFAULT_CMDQ_DEPTH   = 4;
  localparam int DEFAULT_XIMM1Q_DEPTH = 4;

  localparam int CMDQ_CNT_W   = $clog2(DEFAULT_CMDQ_DEPTH) + 1;
  localparam int XIMM1Q_CNT_W = $clog2(DEFAULT_XIMM1Q_DEPTH) + 1;

  typedef logic [DEFAULT_CMD_W-1:0]  cmd_t;
  typedef logic [DEFAULT_XIMM_W-1:0] ximm_t;

endpackage

// File: rtl/enq_fifo.sv
// rtl/enq_fifo.sv - registered-ready FIFO; no flow-through, no full-bypass
module enq_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  input  logic [W-1:0]               enq_bits,
  output logic                       ready,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [W-1:0]               deq_bits,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL     = DEPTH;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_enq;
  logic          do_deq;

  // ready looks only at the registered count, so a same-cycle pop never frees a slot
  assign ready     = (count != FULL);
  assign deq_valid = (count != '0);
  assign deq_bits  = mem[rd_ptr];
  assign do_enq    = enq_valid & ready;
  assign do_deq    = deq_valid & deq_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_deq) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_bits;
  end

endmodule

// File: rtl/cmd_ximm_enq_unit.sv
// rtl/cmd_ximm_enq_unit.sv - atomic cmdq/ximm1q enqueue with replay; REPLAY_STATS_EN adds io_replay_count
module cmd_ximm_enq_unit
  import cmd_ximm_pkg::*;
#(
  parameter int CMD_W        = DEFAULT_CMD_W,
  parameter int XIMM_W       = DEFAULT_XIMM_W,
  parameter int CMDQ_DEPTH   = DEFAULT_CMDQ_DEPTH,
  parameter int XIMM1Q_DEPTH = DEFAULT_XIMM1Q_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            io_valid,
  input  logic                            io_sigs_enq_cmdq,
  input  logic                            io_sigs_enq_ximm1q,
  input  logic [CMD_W-1:0]                io_cmd_bits,
  input  logic [XIMM_W-1:0]               io_ximm1_bits,
  output logic                            io_replay,
  output logic                            io_fire,
  output logic                            io_cmdq_deq_valid,
  input  logic                            io_cmdq_deq_ready,
  output logic [CMD_W-1:0]                io_cmdq_deq_bits,
  output logic                            io_ximm1q_deq_valid,
  input  logic                            io_ximm1q_deq_ready,
  output logic [XIMM_W-1:0]               io_ximm1q_deq_bits,
  output logic [$clog2(CMDQ_DEPTH):0]     io_cmdq_count,
  output logic [$clog2(XIMM1Q_DEPTH):0]   io_ximm1q_count
`ifdef REPLAY_STATS_EN
  ,
  output logic [31:0]                     io_replay_count
`endif
);

  logic cmdq_ready;
  logic ximm1q_ready;

  // a replay blocks both queues, even the one that had room
  assign io_replay = ~reset & io_valid &
                     ((io_sigs_enq_cmdq & ~cmdq_ready) | (io_sigs_enq_ximm1q & ~ximm1q_ready));
  assign io_fire   = ~reset & io_valid & ~io_replay;

  enq_fifo #(.W(CMD_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (io_fire & io_sigs_enq_cmdq),
    .enq_bits  (io_cmd_bits),
    .ready     (cmdq_ready),
    .deq_valid (io_cmdq_deq_valid),
    .deq_ready (io_cmdq_deq_ready),
    .deq_bits  (io_cmdq_deq_bits),
    .count     (io_cmdq_count)
  );

  enq_fifo #(.W(XIMM_W), .DEPTH(XIMM1Q_DEPTH)) u_ximm1q (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (io_fire & io_sigs_enq_ximm1q),
    .enq_bits  (io_ximm1_bits),
    .ready     (ximm1q_ready),
    .deq_valid (io_ximm1q_deq_valid),
    .deq_ready (io_ximm1q_deq_ready),
    .deq_bits  (io_ximm1q_deq_bits),
    .count     (io_ximm1q_count)
  );

`ifdef REPLAY_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      io_replay_count <= '0;
    end else if (io_replay && (io_replay_count != '1)) begin
      io_replay_count <= io_replay_count + 32'd1;
    end
  end
`endif

endmodule
